// File: rtl/debug_pkg.sv
// Shared types for the debug run/step/halt controller.
package debug_pkg;

    typedef enum logic [2:0] {
        S_HALT,
        S_STEP,
        S_RUN,
        S_RUN_N,
        S_GAP
    } dbg_state_t;

    typedef enum logic [1:0] {
        OP_HALT  = 2'd0,
        OP_STEP  = 2'd1,
        OP_RUN   = 2'd2,
        OP_RUN_N = 2'd3
    } dbg_op_t;

endpackage

// File: rtl/dbg_bp_match.sv
// PC breakpoint bank: NUM_BP address/enable slots with an OR-reduced match against core_pc.
module dbg_bp_match #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_BP = 2
) (
    input  logic                      clk,
    input  logic                      areset,
    input  logic                      bp_wr,
    input  logic [$clog2(NUM_BP)-1:0] bp_idx,
    input  logic [DATA_W-1:0]         bp_addr,
    input  logic                      bp_en,
    input  logic [DATA_W-1:0]         core_pc,
    output logic                      bp_match
);
    localparam int unsigned IDX_W = $clog2(NUM_BP);

    logic [DATA_W-1:0] addr_q [NUM_BP];
    logic [NUM_BP-1:0] en_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_BP; i++) begin
                addr_q[i] <= '0;
            end
            en_q <= '0;
        end else if (bp_wr) begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (bp_idx == IDX_W'(i)) begin
                    addr_q[i] <= bp_addr;
                    en_q[i]   <= bp_en;
                end
            end
        end
    end

    always_comb begin
        bp_match = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (en_q[i] && (addr_q[i] == core_pc)) begin
                bp_match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/debug_step_ctrl.sv
// Run/step/halt controller driving core_step/core_debug_mode, with registered channel readback.
// Define DBG_BREAKPOINT_EN to build the PC breakpoint bank and bp_hit logic.
module debug_step_ctrl
    import debug_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_CH = 6,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned NUM_BP = 2
) (
    input  logic                      clk,
    input  logic                      areset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [CNT_W-1:0]          cmd_count,
    input  logic                      bp_wr,
    input  logic [$clog2(NUM_BP)-1:0] bp_idx,
    input  logic [DATA_W-1:0]         bp_addr,
    input  logic                      bp_en,
    input  logic [DATA_W-1:0]         core_pc,
    input  logic [NUM_CH*DATA_W-1:0]  dbg_in,
    input  logic [$clog2(NUM_CH)-1:0] ch_sel,
    output logic                      core_step,
    output logic                      core_debug_mode,
    output logic [DATA_W-1:0]         ch_data,
    output logic [DATA_W-1:0]         step_cnt,
    output logic                      halted,
    output logic                      bp_hit,
    output logic                      cmd_err
);
    localparam int unsigned CH_W = $clog2(NUM_CH);

    dbg_state_t       state_q, state_d;
    dbg_op_t          op;
    logic [CNT_W-1:0] remain_q;
    logic             accept, running, halt_cmd, pulse, bp_stop, bp_match;
    logic [DATA_W-1:0] ch_d;

    assign op       = dbg_op_t'(cmd_op);
    assign accept   = cmd_valid & cmd_ready;
    assign running  = (state_q == S_RUN) || (state_q == S_RUN_N);
    assign halt_cmd = running && accept && (op == OP_HALT);

`ifdef DBG_BREAKPOINT_EN
    dbg_bp_match #(
        .DATA_W (DATA_W),
        .NUM_BP (NUM_BP)
    ) u_bp_match (
        .clk      (clk),
        .areset   (areset),
        .bp_wr    (bp_wr),
        .bp_idx   (bp_idx),
        .bp_addr  (bp_addr),
        .bp_en    (bp_en),
        .core_pc  (core_pc),
        .bp_match (bp_match)
    );
`else
    logic unused_bp;
    assign unused_bp = ^{bp_wr, bp_idx, bp_addr, bp_en, core_pc};
    assign bp_match  = 1'b0;
`endif

    // Priority in RUN/RUN_N: HALT command, then breakpoint, then exhausted count.
    always_comb begin
        state_d = state_q;
        pulse   = 1'b0;
        bp_stop = 1'b0;
        unique case (state_q)
            S_HALT: begin
                if (accept) begin
                    unique case (op)
                        OP_STEP: begin
                            state_d = S_STEP;
                            pulse   = 1'b1;
                        end
                        OP_RUN:   state_d = S_RUN;
                        OP_RUN_N: state_d = S_RUN_N;
                        default:  state_d = S_HALT;
                    endcase
                end
            end
            S_STEP: state_d = S_HALT;
            S_GAP:  state_d = S_RUN_N;
            S_RUN, S_RUN_N: begin
                if (halt_cmd) begin
                    state_d = S_HALT;
                end else if (bp_match) begin
                    state_d = S_HALT;
                    bp_stop = 1'b1;
                end else if (state_q == S_RUN_N) begin
                    if (remain_q == '0) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_GAP;
                        pulse   = 1'b1;
                    end
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    always_comb begin
        ch_d = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ch_sel == CH_W'(k)) begin
                ch_d = dbg_in[k*DATA_W +: DATA_W];
            end
        end
    end

    // Status outputs are decoded from the next state so they are flop outputs themselves.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q         <= S_HALT;
            remain_q        <= '0;
            core_step       <= 1'b0;
            core_debug_mode <= 1'b1;
            halted          <= 1'b1;
            cmd_ready       <= 1'b1;
            step_cnt        <= '0;
            bp_hit          <= 1'b0;
            cmd_err         <= 1'b0;
            ch_data         <= '0;
        end else begin
            state_q         <= state_d;
            core_step       <= pulse;
            halted          <= (state_d == S_HALT);
            core_debug_mode <= (state_d != S_RUN);
            cmd_ready       <= (state_d inside {S_HALT, S_RUN, S_RUN_N});
            ch_data         <= ch_d;
            if (pulse) begin
                step_cnt <= step_cnt + 1'b1;
            end
            if ((state_q == S_HALT) && accept && (op == OP_RUN_N)) begin
                remain_q <= cmd_count;
            end else if (halt_cmd) begin
                remain_q <= '0;
            end else if (pulse && (state_q == S_RUN_N)) begin
                remain_q <= remain_q - 1'b1;
            end
            if ((state_q == S_HALT) && accept) begin
                bp_hit <= 1'b0;
            end else if (bp_stop) begin
                bp_hit <= 1'b1;
            end
            if (running && accept && (op != OP_HALT)) begin
                cmd_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Bench for debug_step_ctrl: directed commands, a schedule-based reference model checked every
// cycle, and literal expectations from the step/run/breakpoint/readback/reset scenarios.
module tb_debug_step_ctrl;
    localparam int DATA_W = 32;
    localparam int NUM_CH = 6;
    localparam int CNT_W  = 16;
    localparam int NUM_BP = 2;
    localparam logic [1:0] C_HALT = 2'd0, C_STEP = 2'd1, C_RUN = 2'd2, C_RUN_N = 2'd3;
`ifdef DBG_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     areset = 1'b1;
    logic                     cmd_valid = 1'b0;
    logic                     cmd_ready;
    logic [1:0]               cmd_op = 2'd0;
    logic [CNT_W-1:0]         cmd_count = '0;
    logic                     bp_wr = 1'b0;
    logic [0:0]               bp_idx = 1'b0;
    logic [DATA_W-1:0]        bp_addr = '0;
    logic                     bp_en = 1'b0;
    logic [DATA_W-1:0]        core_pc = '0;
    logic [NUM_CH*DATA_W-1:0] dbg_in = '0;
    logic [2:0]               ch_sel = 3'd0;
    logic                     core_step, core_debug_mode, halted, bp_hit, cmd_err;
    logic [DATA_W-1:0]        ch_data, step_cnt;

    int n_checks = 0;
    int n_err = 0;

    debug_step_ctrl #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .NUM_BP (NUM_BP)
    ) dut (
        .clk             (clk),
        .areset          (areset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_count       (cmd_count),
        .bp_wr           (bp_wr),
        .bp_idx          (bp_idx),
        .bp_addr         (bp_addr),
        .bp_en           (bp_en),
        .core_pc         (core_pc),
        .dbg_in          (dbg_in),
        .ch_sel          (ch_sel),
        .core_step       (core_step),
        .core_debug_mode (core_debug_mode),
        .ch_data         (ch_data),
        .step_cnt        (step_cnt),
        .halted          (halted),
        .bp_hit          (bp_hit),
        .cmd_err         (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a counted run is a schedule of decision edges two apart, not a state machine.
    localparam int M_IDLE = 0, M_ONE = 1, M_FREE = 2, M_COUNT = 3;
    int          m_mode, m_left, m_due, m_edge;
    bit          m_step, m_bp_hit, m_err, m_ready;
    logic [31:0] m_cnt, m_ch;
    logic [31:0] m_bp_addr [NUM_BP];
    bit          m_bp_en [NUM_BP];

    task automatic model_reset();
        m_mode = M_IDLE; m_left = 0; m_due = 0; m_edge = 0;
        m_step = 0; m_bp_hit = 0; m_err = 0; m_ready = 1;
        m_cnt = 0; m_ch = 0;
        for (int i = 0; i < NUM_BP; i++) begin
            m_bp_addr[i] = 0;
            m_bp_en[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit acc, bpm, pulse;
        int e;
        m_edge++;
        e = m_edge;
        acc = cmd_valid && m_ready;
        bpm = 0;
        pulse = 0;
        for (int i = 0; i < NUM_BP; i++)
            if (BP_EN && m_bp_en[i] && (m_bp_addr[i] == core_pc)) bpm = 1;
        if (m_mode == M_IDLE) begin
            if (acc) begin
                m_bp_hit = 0;
                if (cmd_op == C_STEP) begin
                    m_mode = M_ONE;
                    pulse = 1;
                end else if (cmd_op == C_RUN) begin
                    m_mode = M_FREE;
                end else if (cmd_op == C_RUN_N) begin
                    m_mode = M_COUNT;
                    m_left = int'(cmd_count);
                    m_due = e + 1;
                end
            end
        end else if (m_mode == M_ONE) begin
            m_mode = M_IDLE;
        end else if (acc && cmd_op == C_HALT) begin
            m_mode = M_IDLE;
            m_left = 0;
        end else begin
            if (acc) m_err = 1;
            if (m_mode == M_FREE) begin
                if (bpm) begin
                    m_mode = M_IDLE;
                    m_bp_hit = 1;
                end
            end else if (e == m_due) begin
                if (bpm) begin
                    m_mode = M_IDLE;
                    m_bp_hit = 1;
                end else if (m_left == 0) begin
                    m_mode = M_IDLE;
                end else begin
                    pulse = 1;
                    m_left--;
                    m_due = e + 2;
                end
            end
        end
        if (BP_EN && bp_wr) begin
            m_bp_addr[bp_idx] = bp_addr;
            m_bp_en[bp_idx] = bp_en;
        end
        m_ch = (int'(ch_sel) < NUM_CH) ? dbg_in[int'(ch_sel)*DATA_W +: DATA_W] : 32'h0;
        m_step = pulse;
        m_cnt = m_cnt + 32'(pulse);
        m_ready = (m_mode == M_IDLE) || (m_mode == M_FREE) || (m_mode == M_COUNT && m_due == e + 1);
    endtask

    initial forever begin
        @(negedge clk);
        if (areset) begin
            model_reset();
        end else begin
            model_edge();
            check("core_step", core_step, m_step);
            check("halted", halted, m_mode == M_IDLE);
            check("core_debug_mode", core_debug_mode, m_mode != M_FREE);
            check("cmd_ready", cmd_ready, m_ready);
            check("step_cnt", step_cnt, m_cnt);
            check("bp_hit", bp_hit, m_bp_hit);
            check("cmd_err", cmd_err, m_err);
            check("ch_data", ch_data, m_ch);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [CNT_W-1:0] cnt);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_count = cnt;
        while (!cmd_ready && n < 40) begin
            tick();
            n++;
        end
        check("send_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the end of the test sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, first, last, halt_at, gap_bad;
        logic [31:0] exp_ch;
        for (int k = 0; k < NUM_CH; k++) dbg_in[k*DATA_W +: DATA_W] = 32'(32'hA0 + k);
        tick();
        check("rst_halted", halted, 1);
        check("rst_debug_mode", core_debug_mode, 1);
        check("rst_core_step", core_step, 0);
        check("rst_step_cnt", step_cnt, 0);
        check("rst_ch_data", ch_data, 0);
        check("rst_bp_hit", bp_hit, 0);
        check("rst_cmd_err", cmd_err, 0);
        tick();
        areset = 1'b0;

        // Single steps while halted
        for (int i = 0; i < 3; i++) begin
            send(C_STEP, 0);
            check("step_pulse", core_step, 1);
            check("step_busy", halted, 0);
            tick();
            check("step_pulse_end", core_step, 0);
            check("step_halted", halted, 1);
        end
        check("step_cnt_3", step_cnt, 3);

        // RUN_N 5: pulses on edges 1,3,5,7,9 after acceptance, halted from edge 11
        send(C_RUN_N, 16'd5);
        pulses = 0; first = -1; last = -1; halt_at = -1; gap_bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (core_step) begin
                if (first < 0) first = k;
                else if (k - last != 2) gap_bad++;
                last = k;
                pulses++;
            end
            if (halted && halt_at < 0) halt_at = k;
            tick();
        end
        check("runn_pulses", pulses, 5);
        check("runn_first", first, 1);
        check("runn_spacing", gap_bad, 0);
        check("runn_halt_cycle", halt_at, 11);
        check("runn_step_cnt", step_cnt, 8);

        send(C_RUN_N, 16'd0);
        check("runn0_active", halted, 0);
        tick();
        check("runn0_halted", halted, 1);
        check("runn0_no_pulse", step_cnt, 8);

        // Breakpoint on slot 1 at 0x40 while free-running
        bp_wr = 1'b1; bp_idx = 1'b1; bp_addr = 32'h40; bp_en = 1'b1;
        tick();
        bp_wr = 1'b0;
        core_pc = 32'h0;
        send(C_RUN, 0);
`ifdef DBG_BREAKPOINT_EN
        for (int k = 1; k <= 24 && !halted; k++) begin
            core_pc = 32'(4 * k);
            tick();
        end
        check("bp_halted", halted, 1);
        check("bp_pc", core_pc, 32'h40);
        check("bp_hit_set", bp_hit, 1);
`else
        for (int k = 1; k <= 24; k++) begin
            core_pc = 32'(4 * k);
            tick();
        end
        check("nobp_running", halted, 0);
        check("nobp_free_mode", core_debug_mode, 0);
        check("nobp_hit", bp_hit, 0);
        send(C_HALT, 0);
        check("nobp_halted", halted, 1);
`endif
        core_pc = 32'h100;
        send(C_STEP, 0);
        check("bp_hit_cleared", bp_hit, 0);
        tick();
        check("step_cnt_9", step_cnt, 9);

        // RUN_N 100 interrupted by HALT after ten pulses
        send(C_RUN_N, 16'd100);
        pulses = 0;
        for (int k = 0; k < 60 && pulses < 10; k++) begin
            tick();
            if (core_step) pulses++;
        end
        check("runn100_pulses", pulses, 10);
        send(C_HALT, 0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (core_step) pulses++;
            tick();
        end
        check("halt_no_more_pulses", pulses, 0);
        check("halt_halted", halted, 1);
        check("halt_remain_cleared", dut.remain_q, 0);
        check("halt_step_cnt", step_cnt, 19);

        // STEP while running is dropped and flagged
        send(C_RUN, 0);
        tick();
        tick();
        send(C_STEP, 0);
        check("err_set", cmd_err, 1);
        check("err_still_running", halted, 0);
        check("err_free_mode", core_debug_mode, 0);
        check("err_no_step", step_cnt, 19);
        send(C_HALT, 0);
        check("err_halted", halted, 1);
        check("err_sticky", cmd_err, 1);

        // Channel readback sweep including out-of-range selects
        for (int k = 0; k < 8; k++) begin
            ch_sel = 3'(k);
            tick();
            exp_ch = (k < NUM_CH) ? 32'(32'hA0 + k) : 32'h0;
            check("ch_sweep", ch_data, exp_ch);
        end

        // Asynchronous reset during a RUN_N gap
        send(C_RUN_N, 16'd10);
        for (int k = 0; k < 6 && !core_step; k++) tick();
        check("pre_reset_pulse", core_step, 1);
        #2 areset = 1'b1;
        #1;
        check("arst_core_step", core_step, 0);
        check("arst_halted", halted, 1);
        check("arst_debug_mode", core_debug_mode, 1);
        check("arst_step_cnt", step_cnt, 0);
        check("arst_cmd_err", cmd_err, 0);
        check("arst_remain", dut.remain_q, 0);
        tick();
        tick();
        areset = 1'b0;
        tick();
        check("post_reset_halted", halted, 1);
        check("post_reset_step_cnt", step_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
